mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter for the single-ported unified instruction/data memory of the multicycle ARM system. It sits between memory and two requesters: the `arm` core's `MemWrite`/`Adr`/`WriteData`/`ReadData` port (requester C) and a DMA/debug loader (requester D). Each cycle it grants at most one requester, drives the memory port from the winner and returns registered read data. Arbitration is round-robin with a bounded DMA lock-burst, and the core is stalled through its `c_gnt` signal.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_BURST`, 8, maximum consecutive locked DMA grants while the core is requesting (at least 1)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `c_req`  in  1  core requests an access this cycle
- `c_we`  in  1  core access is a write
- `c_adr`  in  AW  core address
- `c_wdata`  in  DW  core write data
- `c_gnt`  out  1  core access performed this cycle; core holds all state while `c_req && !c_gnt`
- `c_rvalid`  out  1  `c_rdata` holds the result of the previous cycle's granted core read
- `c_rdata`  out  DW  registered core read data
- `d_req`, `d_we`, `d_adr`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_rdata`: same meaning for requester D
- `d_lock`  in  1  D requests to keep the grant for the following cycle (burst)
- `MemWrite`  out  1  memory write strobe
- `Adr`  out  AW  memory address
- `WriteData`  out  DW  memory write data
- `ReadData`  in  DW  memory read data (combinational read of `Adr`)

## Operation
- State: `last` (owner granted most recently, C or D), `locked` (1 bit), `burst_cnt` (width ceil(log2(MAX_BURST+1))), plus `c_rvalid`, `c_rdata`, `d_rvalid`, `d_rdata` registers.
- Grant decision (combinational, same cycle):
  - If `locked && d_req` and (`!c_req` or `burst_cnt < MAX_BURST`): grant D.
  - Else if only one requester is active: grant that requester.
  - Else if both are active: grant the requester that is not `last`.
  - Else: no grant.
- Memory port follows the granted requester: `Adr`/`WriteData` from the winner; `MemWrite = winner_we`.
- When nothing is granted, `Adr`/`WriteData` = 0 and `MemWrite` = 0.
- A request is never partially performed. Requesters hold `req`/`we`/`adr`/`wdata` stable until granted.
- At each clock edge:
  - `last` is set to the granted owner; unchanged if there was no grant.
  - `locked <= d_gnt && d_lock`.
  - `burst_cnt`: incremented on `d_gnt && locked`, saturating at MAX_BURST; cleared otherwise.
  - For a granted read, `x_rdata <= ReadData` and `x_rvalid <= 1`. Otherwise `x_rvalid <= 0` and `x_rdata` keeps its value.
- Lock expiry:
  - When `burst_cnt == MAX_BURST` and `c_req` is active, C wins the next contended cycle, regardless of `last`.
  - The lock drops (`locked <= 0`) because `d_gnt` is 0 in that cycle.
- `d_lock` is ignored in any cycle where D is not granted.

## Timing
- Grant latency: 0 cycles, so an uncontended request is granted in the same cycle it is asserted.
- Write commits at the rising edge that ends the grant cycle.
- Read data latency: 1 cycle. `x_rvalid` is high for exactly one cycle, in the cycle after the grant.
- Worst-case core wait while D is bursting: MAX_BURST cycles after the lock starts, then a guaranteed grant.
- Worst-case D wait without lock: 1 cycle.
- Reset (asynchronous, any time, including mid-burst):
  - `last` = D, so C wins the first contended cycle.
  - `locked`, `burst_cnt`, `c_rvalid`, `d_rvalid` = 0; `c_rdata`, `d_rdata` = 0.
  - While `reset` is high, `c_gnt`, `d_gnt` and `MemWrite` are forced to 0.
  - A write in flight when reset asserts is not performed.
- Simultaneous first requests after reset: C is granted.

## Structure
- Shared package `arb_pkg`:
  - `owner_t` enum (`OWN_C`, `OWN_D`).
  - Default width constants.
- One natural sub-module, `rr_pick2`: the combinational two-way round-robin winner select from (`req_c`, `req_d`, `last`, `force_d`, `force_c`).
- The registers and memory mux stay in `mem_arbiter`. The `arm` top instantiates `mem_arbiter` between the core and memory, with `c_gnt` gating the core's state advance.

## Test plan
- Core only: `c_req=1`, `c_we=0`, `c_adr=0x10`, with memory[0x10]=0xE3A0_0001 -> `c_gnt=1` the same cycle, `Adr=0x10`; next cycle `c_rvalid=1`, `c_rdata=0xE3A0_0001`.
- Contention after reset: both request every cycle with no lock -> grants in the order C, D, C, D. D writes 0xDEAD_BEEF to 0x40, and a later core read of 0x40 returns 0xDEAD_BEEF.
- Locked burst with MAX_BURST=8:
  - Setup: `d_lock=1` and `d_req=1` held, `c_req=1` throughout, with D granted first.
  - Required: D receives 1+8 consecutive grants, then `c_gnt=1` exactly once, then alternation resumes.
- Lock without core demand: `c_req=0`, D locked for 20 cycles -> 20 consecutive `d_gnt`, and `burst_cnt` saturates at 8 without error.
- Reset mid-burst: assert `reset` during a D write grant -> `MemWrite` drops immediately, the memory word is unchanged, and after release the first contended grant goes to C.
- Idle: no requests -> `MemWrite=0`, `Adr=0`, both `rvalid` signals 0, and `last` unchanged.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package arb_pkg;

  localparam int unsigned ARB_AW        = 32;
  localparam int unsigned ARB_DW        = 32;
  localparam int unsigned ARB_MAX_BURST = 8;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_C) ? OWN_D : OWN_C;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin winner select with lock-hold and lock-expiry overrides.
module rr_pick2
  import arb_pkg::*;
(
  input  logic   req_c,
  input  logic   req_d,
  input  owner_t last,
  input  logic   force_d,
  input  logic   force_c,
  output logic   gnt_c,
  output logic   gnt_d
);

  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (force_d && req_d) begin
      gnt_d = 1'b1;
    end else if (force_c && req_c) begin
      gnt_c = 1'b1;
    end else if (req_c && req_d) begin
      // contended: the owner that did not win most recently goes next
      if (other_owner(last) == OWN_C) gnt_c = 1'b1;
      else                            gnt_d = 1'b1;
    end else begin
      gnt_c = req_c;
      gnt_d = req_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between the core (C) and a DMA/debug
// loader (D); round-robin with a bounded locked DMA burst.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW        = ARB_AW,
  parameter int unsigned DW        = ARB_DW,
  parameter int unsigned MAX_BURST = ARB_MAX_BURST
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_adr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          MemWrite,
  output logic [AW-1:0] Adr,
  output logic [DW-1:0] WriteData,
  input  logic [DW-1:0] ReadData
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  owner_t        last;
  logic          locked;
  logic [CW-1:0] burst_cnt;
  logic          pick_c;
  logic          pick_d;
  logic          force_d;
  logic          force_c;

  // D keeps a locked grant until the core has waited out a full burst
  assign force_d = locked && d_req && (!c_req || (burst_cnt < BURST_MAX));
  assign force_c = locked && c_req && (burst_cnt == BURST_MAX);

  rr_pick2 u_pick (
    .req_c   (c_req),
    .req_d   (d_req),
    .last    (last),
    .force_d (force_d),
    .force_c (force_c),
    .gnt_c   (pick_c),
    .gnt_d   (pick_d)
  );

  // Grants and memory port; all forced idle while reset is asserted
  always_comb begin
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    MemWrite  = 1'b0;
    Adr       = '0;
    WriteData = '0;
    if (!reset) begin
      c_gnt = pick_c;
      d_gnt = pick_d;
      if (pick_c) begin
        MemWrite  = c_we;
        Adr       = c_adr;
        WriteData = c_wdata;
      end else if (pick_d) begin
        MemWrite  = d_we;
        Adr       = d_adr;
        WriteData = d_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last      <= OWN_D;
      locked    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      if (c_gnt)      last <= OWN_C;
      else if (d_gnt) last <= OWN_D;
      locked <= d_gnt && d_lock;
      if (d_gnt && locked) begin
        if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + CW'(1);
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  // Registered read return, one cycle after the granted read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= c_gnt && !c_we;
      d_rvalid <= d_gnt && !d_we;
      if (c_gnt && !c_we) c_rdata <= ReadData;
      if (d_gnt && !d_we) d_rdata <= ReadData;
    end
  end

endmodule
